exec_ctrl: RTL and testbench
============================

Name: exec_ctrl

Overview:
Sequencer for the execute datapath: the regs register file and the ALU.
- Accepts one decoded data-processing instruction over a valid/ready handshake.
- Evaluates the ARM condition code against the current flags.
- Drives regs read selects, ALU uop and RHS immediate mux.
- Issues a single-cycle register/flag writeback, then reports completion.
- Sits between decode and the regs/ALU pair; owns every write enable into regs.

Parameters:
DATA_W, 32, datapath width (imm_in, imm_out)
UOP_W, 5, ALU micro-op width
PC_REG, 15, register index treated as PC (writes redirected to pc_write)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr_valid  in  1  decoded instruction present
instr_ready  out  1  controller can accept (high only in IDLE)
cond_in  in  4  ARM condition field
uop_in  in  5  ALU micro-op
rd_in  in  4  destination register
rn_in  in  4  first operand register
rm_in  in  4  second operand register
use_imm_in  in  1  RHS from imm instead of rm
imm_in  in  32  immediate operand
set_flags_in  in  1  S bit: update flags
write_rd_in  in  1  0 for CMP/TST-class ops (no rd write)
flags_cur  in  4  regs flags_out, order [Z,C,N,V] (bit3=Z, bit2=C, bit1=N, bit0=V)
sel_p0  out  4  regs port-0 select
sel_p1  out  4  regs port-1 select
sel_in  out  4  regs write select
uop  out  5  ALU micro-op
rhs_imm_sel  out  1  1: ALU RHS = imm_out, 0: RHS = p1
imm_out  out  32  latched immediate
in_reg_enable  out  1  regs write enable
flags_enable  out  1  flag register write enable
pc_write  out  1  write ALU result to PC instead of regs file
done  out  1  one-cycle completion pulse
skipped  out  1  qualifies done: condition failed, nothing written

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; all latched fields = 0.
  - All outputs 0, except instr_ready = 1 once reset_n is high.
  - instr_valid is ignored while reset_n is low.
- Reset mid-operation: aborts immediately and returns to IDLE. No write enable may glitch high.
- Handshake:
  - Transfer occurs on a rising edge with instr_valid & instr_ready.
  - All *_in fields are latched at that edge; later input changes are ignored until the next IDLE.
- States:
  - IDLE: instr_ready = 1. On transfer -> COND.
  - COND: evaluate latched cond against flags_cur.
    - Pass -> EXEC.
    - Fail -> DONE with skipped latched to 1.
  - EXEC: sel_p0 = rn, sel_p1 = rm, uop = uop_in, rhs_imm_sel = use_imm, imm_out = imm. Next state -> WB.
  - WB:
    - Operand selects, uop and imm are held from EXEC.
    - sel_in = rd.
    - in_reg_enable = write_rd & (rd != PC_REG).
    - pc_write = write_rd & (rd == PC_REG).
    - flags_enable = set_flags.
    - All enables are high for exactly this one cycle. Next state -> DONE.
  - DONE: done = 1, skipped as latched; selects return to 0. Next state -> IDLE.
- Latency, counted from the accept edge:
  - Executed instruction: done is high in cycle 4. Throughput is 1 instruction per 5 cycles.
  - Skipped instruction: done is high in cycle 2. Throughput is 1 per 3 cycles.
- Condition table:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) always; 1111 never (treated as failed).
- flags_cur is sampled in COND only. Flags written by the previous instruction's WB are visible because at least 2 edges separate them.
- write_rd = 0 and set_flags = 0: the instruction runs through all states, no enable is raised, and done fires normally.
- Outside WB, in_reg_enable, flags_enable and pc_write are 0.
- Outside EXEC/WB, sel_p0, sel_p1, sel_in and uop are 0.

Decomposition:
- Package exec_pkg holds:
  - state encoding (IDLE, COND, EXEC, WB, DONE; 3 bits);
  - condition-code constants;
  - flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0);
  - UOP_W, PC_REG.
- One natural sub-module: cond_check, purely combinational: (cond[3:0], flags[3:0]) -> pass.
- The FSM, field latches and output decode stay in exec_ctrl.

Test Plan:
1. Reset, then cond=AL, uop=SUB(00010), rn=1, rm=0, rd=2, write_rd=1, set_flags=1, with r1=1, r0=2 preloaded:
   - in_reg_enable high for one cycle with sel_in=2, in cycle 3;
   - r2 = 0xFFFFFFFF, N=1;
   - done in cycle 4, skipped=0.
2. flags_cur Z=1, cond=NE:
   - done in cycle 2 with skipped=1;
   - in_reg_enable, flags_enable and pc_write never assert.
3. cond=AL, write_rd=0, set_flags=1 (CMP r0,r0):
   - flags_enable only;
   - in_reg_enable stays 0;
   - Z becomes 1.
4. rd=15, use_imm=1, imm=0x100: pc_write=1 and rhs_imm_sel=1 in WB; in_reg_enable=0.
5. Deassert reset_n while in WB: all enables drop asynchronously; after release, state IDLE with instr_ready=1 and no write having occurred.
6. Hold instr_valid continuously with two distinct instructions queued: the second is accepted only in IDLE after the first's done, and its fields are unaffected by input changes mid-execution.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute-stage sequencer: FSM encoding,
// ARM condition codes, flag bit positions in the {Z,C,N,V} nibble.
package exec_pkg;

  localparam int         UOP_W  = 5;
  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_COND = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluator; purely combinational, zero latency.
// The reserved 1111 code never passes.
module cond_check
  import exec_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic z, c, n, v;

  always_comb begin
    z = flags_i[FLAG_Z];
    c = flags_i[FLAG_C];
    n = flags_i[FLAG_N];
    v = flags_i[FLAG_V];
    pass_o = 1'b0;
    unique case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Execute sequencer: accept -> COND -> EXEC -> WB -> DONE; done in cycle 4 (2 if skipped).
// instr_ready is high only in IDLE, so decode stalls for the whole instruction.
module exec_ctrl #(
  parameter int         DATA_W = 32,
  parameter int         UOP_W  = exec_pkg::UOP_W,
  parameter logic [3:0] PC_REG = exec_pkg::PC_REG
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        cond_in,
  input  logic [UOP_W-1:0]  uop_in,
  input  logic [3:0]        rd_in,
  input  logic [3:0]        rn_in,
  input  logic [3:0]        rm_in,
  input  logic              use_imm_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              set_flags_in,
  input  logic              write_rd_in,
  input  logic [3:0]        flags_cur,
  output logic [3:0]        sel_p0,
  output logic [3:0]        sel_p1,
  output logic [3:0]        sel_in,
  output logic [UOP_W-1:0]  uop,
  output logic              rhs_imm_sel,
  output logic [DATA_W-1:0] imm_out,
  output logic              in_reg_enable,
  output logic              flags_enable,
  output logic              pc_write,
  output logic              done,
  output logic              skipped
);

  import exec_pkg::*;

  state_e              state_q;
  logic [3:0]          cond_q, rd_q, rn_q, rm_q;
  logic [UOP_W-1:0]    uop_q;
  logic                use_imm_q, set_flags_q, write_rd_q;
  logic [DATA_W-1:0]   imm_q;

  logic [3:0]          sel_p0_q, sel_p1_q, sel_in_q;
  logic [UOP_W-1:0]    uop_out_q;
  logic                rhs_q, in_reg_en_q, flags_en_q, pc_write_q, done_q, skipped_q;
  logic [DATA_W-1:0]   imm_out_q;
  logic                cond_pass;

  cond_check u_cond_check (
    .cond_i  (cond_q),
    .flags_i (flags_cur),
    .pass_o  (cond_pass)
  );

  // Outputs are registered on the transition into the state that owns them,
  // so every enable comes straight off a flop cleared by the async reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cond_q      <= '0;
      uop_q       <= '0;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      use_imm_q   <= 1'b0;
      imm_q       <= '0;
      set_flags_q <= 1'b0;
      write_rd_q  <= 1'b0;
      sel_p0_q    <= '0;
      sel_p1_q    <= '0;
      sel_in_q    <= '0;
      uop_out_q   <= '0;
      rhs_q       <= 1'b0;
      imm_out_q   <= '0;
      in_reg_en_q <= 1'b0;
      flags_en_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
      skipped_q   <= 1'b0;
    end else begin
      in_reg_en_q <= 1'b0;
      flags_en_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            cond_q      <= cond_in;
            uop_q       <= uop_in;
            rd_q        <= rd_in;
            rn_q        <= rn_in;
            rm_q        <= rm_in;
            use_imm_q   <= use_imm_in;
            imm_q       <= imm_in;
            set_flags_q <= set_flags_in;
            write_rd_q  <= write_rd_in;
            state_q     <= ST_COND;
          end
        end
        ST_COND: begin
          if (cond_pass) begin
            sel_p0_q  <= rn_q;
            sel_p1_q  <= rm_q;
            uop_out_q <= uop_q;
            rhs_q     <= use_imm_q;
            imm_out_q <= imm_q;
            state_q   <= ST_EXEC;
          end else begin
            done_q    <= 1'b1;
            skipped_q <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_EXEC: begin
          sel_in_q    <= rd_q;
          in_reg_en_q <= write_rd_q && (rd_q != PC_REG);
          pc_write_q  <= write_rd_q && (rd_q == PC_REG);
          flags_en_q  <= set_flags_q;
          state_q     <= ST_WB;
        end
        ST_WB: begin
          sel_p0_q  <= '0;
          sel_p1_q  <= '0;
          sel_in_q  <= '0;
          uop_out_q <= '0;
          rhs_q     <= 1'b0;
          imm_out_q <= '0;
          done_q    <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          skipped_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready   = reset_n && (state_q == ST_IDLE);
  assign sel_p0        = sel_p0_q;
  assign sel_p1        = sel_p1_q;
  assign sel_in        = sel_in_q;
  assign uop           = uop_out_q;
  assign rhs_imm_sel   = rhs_q;
  assign imm_out       = imm_out_q;
  assign in_reg_enable = in_reg_en_q;
  assign flags_enable  = flags_en_q;
  assign pc_write      = pc_write_q;
  assign done          = done_q;
  assign skipped       = skipped_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Scoreboard bench for exec_ctrl with a small behavioural regs/ALU model around it.
module tb_exec_ctrl;

  localparam logic [4:0] U_SUB = 5'b00010;
  localparam logic [4:0] U_ADD = 5'b00100;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  cond_in, rd_in, rn_in, rm_in;
  logic [4:0]  uop_in;
  logic        use_imm_in, set_flags_in, write_rd_in;
  logic [31:0] imm_in;
  logic [3:0]  flags_cur;
  logic [3:0]  sel_p0, sel_p1, sel_in;
  logic [4:0]  uop;
  logic        rhs_imm_sel, in_reg_enable, flags_enable, pc_write, done, skipped;
  logic [31:0] imm_out;

  always #5 clock = ~clock;

  exec_ctrl dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .cond_in(cond_in), .uop_in(uop_in), .rd_in(rd_in), .rn_in(rn_in), .rm_in(rm_in),
    .use_imm_in(use_imm_in), .imm_in(imm_in), .set_flags_in(set_flags_in),
    .write_rd_in(write_rd_in), .flags_cur(flags_cur), .sel_p0(sel_p0), .sel_p1(sel_p1),
    .sel_in(sel_in), .uop(uop), .rhs_imm_sel(rhs_imm_sel), .imm_out(imm_out),
    .in_reg_enable(in_reg_enable), .flags_enable(flags_enable), .pc_write(pc_write),
    .done(done), .skipped(skipped)
  );

  // Behavioural regs file + ALU, flags nibble {Z,C,N,V}
  logic [31:0] rf_m [16];
  logic [31:0] pc_m;
  logic [3:0]  flags_m;
  logic        model_rdy = 1'b0;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [32:0] alu_wide;
  logic        alu_c, alu_v;

  assign flags_cur = flags_m;

  always_comb begin
    alu_a    = rf_m[sel_p0];
    alu_b    = rhs_imm_sel ? imm_out : rf_m[sel_p1];
    alu_wide = '0;
    alu_res  = alu_b;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    if (uop == U_ADD) begin
      alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      alu_res  = alu_wide[31:0];
      alu_c    = alu_wide[32];
      alu_v    = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
    end else if (uop == U_SUB) begin
      alu_res  = alu_a - alu_b;
      alu_c    = (alu_a >= alu_b);
      alu_v    = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
    end
  end

  always @(posedge clock) begin
    if (!model_rdy) begin
      for (int i = 0; i < 16; i++) rf_m[i] <= 32'h0;
      rf_m[0] <= 32'd2;
      rf_m[1] <= 32'd1;
      pc_m    <= 32'h0;
      flags_m <= 4'h0;
    end else begin
      if (in_reg_enable) rf_m[sel_in] <= alu_res;
      if (pc_write) pc_m <= alu_res;
      if (flags_enable) flags_m <= {alu_res == 32'h0, alu_c, alu_res[31], alu_v};
    end
  end

  // Scoreboard
  typedef struct {
    logic       skip;
    int         lat;
    int         we;
    int         fe;
    int         pw;
    logic [3:0] wsel;
    logic       rhs;
  } exp_t;

  exp_t exp_q[$];
  int   acc_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  int         acc_cyc = 0;
  int         we_c = 0, fe_c = 0, pw_c = 0;
  logic [3:0] ws = 4'h0;
  logic       rhs_s = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      we_c = 0; fe_c = 0; pw_c = 0; ws = 4'h0; rhs_s = 1'b0;
    end else begin
      if (instr_valid && instr_ready) begin
        acc_cyc = cyc + 1;
        acc_log.push_back(cyc + 1);
      end
      if (in_reg_enable) begin we_c++; ws = sel_in; end
      if (pc_write) begin pw_c++; ws = sel_in; end
      if (flags_enable) fe_c++;
      if (in_reg_enable || flags_enable || pc_write) rhs_s = rhs_imm_sel;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("skipped", skipped, e.skip);
          chk("done_latency", cyc - acc_cyc + 1, e.lat);
          chk("in_reg_enable_cycles", we_c, e.we);
          chk("flags_enable_cycles", fe_c, e.fe);
          chk("pc_write_cycles", pw_c, e.pw);
          if (e.we != 0 || e.pw != 0) chk("wb_sel_in", ws, e.wsel);
          if (e.we != 0 || e.pw != 0 || e.fe != 0) chk("wb_rhs_imm_sel", rhs_s, e.rhs);
        end
        we_c = 0; fe_c = 0; pw_c = 0; ws = 4'h0; rhs_s = 1'b0;
      end
    end
  end

  // Drive one instruction and return just after its accept edge (valid left high).
  task automatic send(input logic [3:0] c, input logic [4:0] u, input logic [3:0] rd,
                      input logic [3:0] rn, input logic [3:0] rm, input logic ui,
                      input logic [31:0] imm, input logic sf, input logic wr, input logic skip);
    exp_t e;
    int   n;
    @(negedge clock);
    cond_in = c; uop_in = u; rd_in = rd; rn_in = rn; rm_in = rm;
    use_imm_in = ui; imm_in = imm; set_flags_in = sf; write_rd_in = wr;
    instr_valid = 1'b1;
    e.skip = skip;
    e.lat  = skip ? 2 : 4;
    e.we   = (!skip && wr && rd != 4'd15) ? 1 : 0;
    e.pw   = (!skip && wr && rd == 4'd15) ? 1 : 0;
    e.fe   = (!skip && sf) ? 1 : 0;
    e.wsel = rd;
    e.rhs  = ui;
    exp_q.push_back(e);
    n = 0;
    while (!instr_ready && n < 50) begin @(negedge clock); n++; end
    if (!instr_ready) chk("accept_timeout", 0, 1);
    @(posedge clock);
  endtask

  task automatic drain();
    int n;
    @(negedge clock);
    instr_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(negedge clock); n++; end
    chk("scoreboard_drained", exp_q.size(), 0);
    @(negedge clock);
  endtask

  logic [3:0] ctab_c [9];
  logic       ctab_s [9];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    instr_valid = 1'b1;
    cond_in = 4'hE; uop_in = U_ADD; rd_in = 4'd9; rn_in = 4'd1; rm_in = 4'd0;
    use_imm_in = 1'b0; imm_in = 32'h0; set_flags_in = 1'b1; write_rd_in = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    model_rdy = 1'b1;
    chk("rst_instr_ready", instr_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_skipped", skipped, 0);
    chk("rst_enables", {in_reg_enable, flags_enable, pc_write}, 0);
    chk("rst_selects", {sel_p0, sel_p1, sel_in, uop}, 0);
    chk("rst_imm", {rhs_imm_sel, imm_out}, 0);
    instr_valid = 1'b0;
    reset_n = 1'b1;
    #1 chk("post_rst_ready", instr_ready, 1);

    // SUB r2 = r1 - r0 = 1 - 2, sets N
    send(4'hE, U_SUB, 4'd2, 4'd1, 4'd0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t1_r2", rf_m[2], 32'hFFFF_FFFF);
    chk("t1_flags", flags_m, 4'b0010);

    // Flags now Z0 C0 N1 V0; no-write instructions exercise the condition table
    ctab_c = '{4'h4, 4'h5, 4'hB, 4'hA, 4'h8, 4'h9, 4'hF, 4'h3, 4'h6};
    ctab_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      send(ctab_c[i], U_ADD, 4'd7, 4'd1, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0, ctab_s[i]);
      drain();
    end
    chk("cond_no_write_r7", rf_m[7], 0);

    // CMP r0,r0 -> Z=1, C=1
    send(4'hE, U_SUB, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drain();
    chk("t3_flags", flags_m, 4'b1100);
    chk("t3_r0_kept", rf_m[0], 32'd2);

    // Flags Z1 C1 N0 V0: NE skips (writes would otherwise hit r8 and flags)
    ctab_c = '{4'h1, 4'h0, 4'h8, 4'hC, 4'hD, 4'h2, 4'h7, 4'hE, 4'hF};
    ctab_s = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    send(ctab_c[0], U_ADD, 4'd8, 4'd1, 4'd0, 1'b0, 32'h0, 1'b1, 1'b1, ctab_s[0]);
    drain();
    chk("t2_r8_untouched", rf_m[8], 0);
    chk("t2_flags_untouched", flags_m, 4'b1100);
    for (int i = 1; i < 9; i++) begin
      send(ctab_c[i], U_ADD, 4'd7, 4'd1, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0, ctab_s[i]);
      drain();
    end

    // PC write via immediate: pc = r1 + 0x100
    send(4'hE, U_ADD, 4'd15, 4'd1, 4'd0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    drain();
    chk("t4_pc", pc_m, 32'h101);
    chk("t4_r15_file", rf_m[15], 0);

    // Back-to-back with valid held: B waits for A, garbage after B's accept is ignored
    acc_log.delete();
    send(4'hE, U_ADD, 4'd4, 4'd1, 4'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    send(4'hE, U_ADD, 4'd5, 4'd4, 4'd0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
    #1;
    instr_valid = 1'b0;
    cond_in = 4'hF; uop_in = U_SUB; rd_in = 4'd6; rn_in = 4'd0; rm_in = 4'd1;
    use_imm_in = 1'b0; imm_in = 32'hDEAD; set_flags_in = 1'b1; write_rd_in = 1'b1;
    drain();
    if (acc_log.size() == 2) chk("t6_accept_spacing", acc_log[1] - acc_log[0], 5);
    else chk("t6_accept_count", acc_log.size(), 2);
    chk("t6_r4", rf_m[4], 32'd3);
    chk("t6_r5", rf_m[5], 32'h13);
    chk("t6_r6", rf_m[6], 0);
    chk("t6_flags", flags_m, 4'b1100);

    // Reset asserted while in WB
    send(4'hE, U_ADD, 4'd3, 4'd1, 4'd0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    instr_valid = 1'b0;
    n = 0;
    while (!in_reg_enable && n < 10) begin @(negedge clock); n++; end
    chk("t5_reached_wb", in_reg_enable, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_enables_async", {in_reg_enable, flags_enable, pc_write}, 0);
    chk("t5_done_ready", {done, instr_ready}, 0);
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("t5_ready_after", instr_ready, 1);
    chk("t5_r3_unwritten", rf_m[3], 0);
    chk("t5_flags_unwritten", flags_m, 4'b1100);
    repeat (2) @(negedge clock);
    chk("t5_still_idle", {instr_ready, done}, 2'b10);

    send(4'hE, U_ADD, 4'd3, 4'd1, 4'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drain();
    chk("t5_r3_retry", rf_m[3], 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
